// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions for the sequential divider: FSM states and timing constants.
package alu_defs_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER = DIV_WIDTH;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] dvsr_ext;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] rem_sel;
  logic           no_borrow;
  logic           unused_rem_msb;

  assign rem_sh   = {rem_i, quo_i[WIDTH-1]};
  assign dvsr_ext = {1'b0, dvsr_i};

  // Subtract as add-of-complement; the carry out is set exactly when there is no borrow.
  assign {no_borrow, trial} = {1'b0, rem_sh} + {1'b0, ~dvsr_ext} + (WIDTH + 2)'(1);

  // The kept value is always below the divisor, so its top bit is zero.
  assign rem_sel        = no_borrow ? trial : rem_sh;
  assign rem_o          = rem_sel[WIDTH-1:0];
  assign unused_rem_msb = rem_sel[WIDTH];
  assign quo_o          = {quo_i[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (quotient -> LO, remainder -> HI), one bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement signed divide; otherwise unsigned.
module seq_divider
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign a_neg = Ra[WIDTH-1];
  assign b_neg = Rb[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? -Ra : Ra;
  assign b_mag = b_neg ? -Rb : Rb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          if (Rb == '0) begin
            dz_d    = 1'b1;
            quo_d   = DIV_ZERO_QUOT;
            rem_d   = Ra;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            quo_d   = a_mag;
            rem_d   = '0;
            dvsr_d  = b_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = FIXUP;
      end
      FIXUP: begin
        // Truncation toward zero: remainder follows the dividend's sign.
        if (qneg_q) quo_d = -quo_q;
        if (rneg_q) rem_d = -rem_q;
        state_d = DONE;
      end
      DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        quotient_d  = quo_q;
        remainder_d = rem_q;
        div_zero_d  = dz_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand sequences for busy-start, abort and held start.
module tb_seq_divider;
  import alu_defs_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ra = '0;
  logic [W-1:0] rb = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[12];

  seq_divider dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .Ra       (ra),
    .Rb       (rb),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge with operands scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    ra = a;
    rb = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    ra = $urandom;
    rb = $urandom;
  endtask

  task automatic wait_done(input int max_cyc, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, bc, exp_lat;
    exp_lat = v.dz ? 1 : DIV_LATENCY;
    launch(v.a, v.b);
    check($sformatf("v%0d_dz_cleared_on_start", idx), W'(div_zero), W'(0));
    wait_done(100, lat, bc);
    check($sformatf("v%0d_latency", idx), W'(lat), W'(exp_lat));
    check($sformatf("v%0d_busy_cycles", idx), W'(bc), W'(exp_lat));
    check($sformatf("v%0d_quotient", idx), quotient, v.q);
    check($sformatf("v%0d_remainder", idx), remainder, v.r);
    check($sformatf("v%0d_div_zero", idx), W'(div_zero), W'(v.dz));
    check($sformatf("v%0d_busy_at_done", idx), W'(busy), W'(0));
    @(posedge clock);
    #1;
    check($sformatf("v%0d_done_single", idx), W'(done), W'(0));
    check($sformatf("v%0d_quotient_held", idx), quotient, v.q);
  endtask

  initial begin
    int lat, bc, done_cnt;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[2] = '{32'd5, 32'd0, DIV_ZERO_QUOT, 32'd5, 1'b1};
    vecs[6] = '{32'hFFFF_FFF9, 32'd0, DIV_ZERO_QUOT, 32'hFFFF_FFF9, 1'b1};
    vecs[7] = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    vecs[9] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vecs[10] = '{32'd1000000, 32'd1, 32'd1000000, 32'd0, 1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[1] = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0};
    vecs[11] = '{32'hDEAD_BEEF, 32'h0001_0000, 32'hFFFF_DEAE, 32'hFFFF_BEEF, 1'b0};
`else
    vecs[1] = '{32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0};
    vecs[5] = '{32'd100, 32'hFFFF_FFF9, 32'd0, 32'd100, 1'b0};
    vecs[11] = '{32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0};
`endif

    #12;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_div_zero", W'(div_zero), W'(0));
    clear_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // A second start five cycles into a divide must be ignored.
    launch(32'd100, 32'd7);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1;
    ra = 32'd9;
    rb = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("ign_busy", W'(busy), W'(1));
    wait_done(100, lat, bc);
    check("ign_latency", W'(lat), W'(DIV_LATENCY - 5));
    check("ign_quotient", quotient, 32'd14);
    check("ign_remainder", remainder, 32'd2);

    // Abort mid-operation: immediate reset values and no done pulse afterwards.
    launch(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    clear_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    #1;
    clear_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", W'(done_cnt), W'(0));
    check("abort_idle_busy", W'(busy), W'(0));
    launch(32'd9, 32'd3);
    wait_done(100, lat, bc);
    check("fresh_latency", W'(lat), W'(DIV_LATENCY));
    check("fresh_quotient", quotient, 32'd3);
    check("fresh_remainder", remainder, 32'd0);

    // Start held high through DONE: the next op is taken only once back in IDLE.
    start = 1'b1;
    ra = 32'd20;
    rb = 32'd6;
    @(posedge clock);
    #1;
    wait_done(100, lat, bc);
    check("hold_latency", W'(lat), W'(DIV_LATENCY));
    check("hold_busy_at_done", W'(busy), W'(0));
    check("hold_quotient", quotient, 32'd3);
    check("hold_remainder", remainder, 32'd2);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("hold_reaccept_busy", W'(busy), W'(1));
    wait_done(100, lat, bc);
    check("hold2_latency", W'(lat), W'(DIV_LATENCY));
    check("hold2_quotient", quotient, 32'd3);
    check("hold2_remainder", remainder, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
